// File: rtl/axi4_wlast_checker.sv
// axi4_wlast_checker
//   Per-master-port AXI4 write-burst checker. It records the AWLEN of each
//   accepted AW, counts W beats against the oldest outstanding burst, and
//   reports WLAST on the wrong beat, WLAST missing on the expected beat,
//   W data with no outstanding address, and AW overflow of the length FIFO.
//
// Ports
//   aclk, aresetn          clock, synchronous active-low reset
//   awvalid/awready/awlen  AW handshake and burst length (beats-1)
//   wvalid/wready/wlast    W handshake and last-beat marker
//   clr                    clears burst_cnt, err_cnt, err_sticky (FIFO untouched)
//   err_valid              one-cycle pulse, error detected
//   err_code               1=WLAST_EARLY 2=WLAST_MISSING 3=W_NO_AW 4=AW_OVERFLOW
//   err_beat               1-based beat index of the offending beat (0 for code 4)
//   err_exp_len            expected beats of the burst in error (0 for codes 3/4)
//   burst_done             one-cycle pulse, burst closed correctly
//   outstanding            AW entries held in the length FIFO
//   burst_cnt, err_cnt     saturating counters
//   err_sticky             set on any error, cleared by reset or clr
module axi4_wlast_checker #(
  parameter int LEN_FIFO_DEPTH = 8,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic                              awvalid,
  input  logic                              awready,
  input  logic [7:0]                        awlen,
  input  logic                              wvalid,
  input  logic                              wready,
  input  logic                              wlast,
  input  logic                              clr,
  output logic                              err_valid,
  output logic [2:0]                        err_code,
  output logic [8:0]                        err_beat,
  output logic [8:0]                        err_exp_len,
  output logic                              burst_done,
  output logic [$clog2(LEN_FIFO_DEPTH):0]   outstanding,
  output logic [CNT_WIDTH-1:0]              burst_cnt,
  output logic [CNT_WIDTH-1:0]              err_cnt,
  output logic                              err_sticky
);

  localparam int PW = $clog2(LEN_FIFO_DEPTH);
  localparam int OW = PW + 1;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_EARLY   = 3'd1;
  localparam logic [2:0] ERR_MISSING = 3'd2;
  localparam logic [2:0] ERR_NO_AW   = 3'd3;
  localparam logic [2:0] ERR_OVF     = 3'd4;

  logic [7:0]    len_mem [LEN_FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [OW-1:0] count;
  logic [8:0]    beat;

  logic          aw_hs, w_hs, fifo_empty, fifo_full, have_head;
  logic [7:0]    head_len;
  logic [8:0]    exp_len, beat_inc, beat_nxt;
  logic          pop, done, w_err, ovf, push_store, pop_fifo;
  logic [2:0]    w_code;
  logic [1:0]    err_inc;
  logic [CNT_WIDTH:0] err_sum, burst_sum;

  assign aw_hs      = awvalid & awready;
  assign w_hs       = wvalid & wready;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == OW'(LEN_FIFO_DEPTH));
  // An AW accepted in the same cycle as the first beat on an empty FIFO
  // serves directly as the head.
  assign head_len   = fifo_empty ? awlen : len_mem[rd_ptr];
  assign have_head  = ~fifo_empty | aw_hs;
  assign exp_len    = {1'b0, head_len} + 9'd1;
  assign beat_inc   = beat + 9'd1;

  always_comb begin
    pop      = 1'b0;
    done     = 1'b0;
    w_err    = 1'b0;
    w_code   = ERR_NONE;
    beat_nxt = beat;
    if (w_hs) begin
      if (!have_head) begin
        w_err    = 1'b1;
        w_code   = ERR_NO_AW;
        beat_nxt = wlast ? 9'd0 : beat_inc;
      end else if (wlast && beat_inc == exp_len) begin
        pop      = 1'b1;
        done     = 1'b1;
        beat_nxt = 9'd0;
      end else if (wlast && beat_inc < exp_len) begin
        pop      = 1'b1;
        w_err    = 1'b1;
        w_code   = ERR_EARLY;
        beat_nxt = 9'd0;
      end else if (beat_inc >= exp_len) begin
        // Beats left over from address-less traffic can already exceed a
        // short burst; the expected beat has passed, so treat it as missing.
        pop      = 1'b1;
        w_err    = 1'b1;
        w_code   = ERR_MISSING;
        beat_nxt = 9'd0;
      end else begin
        beat_nxt = beat_inc;
      end
    end
  end

  assign ovf        = aw_hs & fifo_full & ~pop;
  // A bypassed AW that is consumed in the same cycle never enters the FIFO.
  assign push_store = aw_hs & ~ovf & ~(fifo_empty & pop);
  assign pop_fifo   = pop & ~fifo_empty;
  assign err_inc    = {1'b0, w_err} + {1'b0, ovf};
  assign err_sum    = {1'b0, err_cnt} + (CNT_WIDTH+1)'(err_inc);
  assign burst_sum  = {1'b0, burst_cnt} + (CNT_WIDTH+1)'(done);

  always_ff @(posedge aclk) begin
    if (push_store) len_mem[wr_ptr] <= awlen;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      beat        <= '0;
      err_valid   <= 1'b0;
      err_code    <= ERR_NONE;
      err_beat    <= '0;
      err_exp_len <= '0;
      burst_done  <= 1'b0;
      outstanding <= '0;
      burst_cnt   <= '0;
      err_cnt     <= '0;
      err_sticky  <= 1'b0;
    end else begin
      beat <= beat_nxt;
      if (push_store) wr_ptr <= wr_ptr + 1'b1;
      if (pop_fifo)   rd_ptr <= rd_ptr + 1'b1;
      case ({push_store, pop_fifo})
        2'b10:   begin count <= count + 1'b1; outstanding <= count + 1'b1; end
        2'b01:   begin count <= count - 1'b1; outstanding <= count - 1'b1; end
        default: outstanding <= count;
      endcase

      burst_done <= done;
      err_valid  <= w_err | ovf;
      if (w_err) begin
        err_code    <= w_code;
        err_beat    <= beat_inc;
        err_exp_len <= (w_code == ERR_NO_AW) ? 9'd0 : exp_len;
      end else if (ovf) begin
        err_code    <= ERR_OVF;
        err_beat    <= 9'd0;
        err_exp_len <= 9'd0;
      end else begin
        err_code    <= ERR_NONE;
        err_beat    <= 9'd0;
        err_exp_len <= 9'd0;
      end

      if (clr) begin
        burst_cnt  <= '0;
        err_cnt    <= '0;
        err_sticky <= 1'b0;
      end else begin
        burst_cnt  <= burst_sum[CNT_WIDTH] ? '1 : burst_sum[CNT_WIDTH-1:0];
        err_cnt    <= err_sum[CNT_WIDTH]   ? '1 : err_sum[CNT_WIDTH-1:0];
        if (w_err | ovf) err_sticky <= 1'b1;
      end
    end
  end

endmodule
